// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
//   Packet-level round-robin arbiter merging four valid/ready beat streams
//   into one registered output stream. A grant is held for a whole packet,
//   which ends with the beat carrying s_last. After each packet the arbiter
//   spends at least one cycle idle. The next grant search then starts just
//   above the source that was last served.
//
// Parameters
//   DATA_W    width of every data bus
//   WDOG_CYC  number of stall cycles tolerated before a grant is aborted
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   s_valid  in   [3:0]  per-source beat valid
//   s_last   in   [3:0]  per-source last beat of packet
//   s_data   in   [4*DATA_W-1:0]  source i in bits [i*DATA_W +: DATA_W]
//   s_ready  out  [3:0]  per-source ready, at most one bit high
//   m_valid  out  registered output beat valid
//   m_last   out  registered output last beat
//   m_data   out  [DATA_W-1:0]  registered output data
//   m_src    out  [1:0]  source index of the current output beat
//   m_ready  in   downstream ready
//   err      out  one-cycle watchdog abort pulse
//
// Build option
//   ARB_WDOG_EN  When this macro is defined, a stalled grant is aborted
//                after WDOG_CYC cycles without s_valid from the granted
//                source. When it is undefined, err is tied low and a
//                stalled grant is held indefinitely.
// ---------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int WDOG_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            s_valid,
    input  logic [3:0]            s_last,
    input  logic [4*DATA_W-1:0]   s_data,
    output logic [3:0]            s_ready,
    output logic                  m_valid,
    output logic                  m_last,
    output logic [DATA_W-1:0]     m_data,
    output logic [1:0]            m_src,
    input  logic                  m_ready,
    output logic                  err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          ptr_q;
    logic [1:0]          g_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;
    logic [1:0]          m_src_q;

    logic [DATA_W-1:0]   src_data [4];
    logic                out_free;
    logic                accept;
    logic                sel_valid;
    logic [1:0]          sel_idx;
    logic                wdog_fire;

    // The output register can take a new beat when it is empty or being drained.
    assign out_free = !m_valid_q || m_ready;

    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        assign src_data[gi] = s_data[gi*DATA_W +: DATA_W];
        assign s_ready[gi]  = (state_q == ST_BUSY) && (g_q == 2'(gi)) && out_free;
    end

    assign accept = s_valid[g_q] && s_ready[g_q];

    // Rotating priority: the first requester at or after ptr+1, wrapping mod 4.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            if (!sel_valid && s_valid[ptr_q + 2'(k)]) begin
                sel_valid = 1'b1;
                sel_idx   = ptr_q + 2'(k);
            end
        end
    end

`ifdef ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    // Abort on the edge that closes the WDOG_CYC-th consecutive stall cycle.
    // A beat cannot be accepted on that edge, because s_valid[g] is low.
    assign wdog_fire = (state_q == ST_BUSY) && !s_valid[g_q]
                       && (wdog_q == WD_W'(WDOG_CYC - 1));
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wdog_fire;
            if (state_q != ST_BUSY || accept || wdog_fire) begin
                wdog_q <= '0;
            end else if (!s_valid[g_q]) begin
                wdog_q <= wdog_q + 1'b1;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd3;
            g_q       <= 2'd0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_src_q   <= 2'd0;
        end else begin
            // Output register: a new beat has priority over draining.
            if (accept) begin
                m_valid_q <= 1'b1;
                m_last_q  <= s_last[g_q];
                m_data_q  <= src_data[g_q];
                m_src_q   <= g_q;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        g_q     <= sel_idx;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if ((accept && s_last[g_q]) || wdog_fire) begin
                        ptr_q   <= g_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign m_src   = m_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_rr_arbiter
//   Each source is a queue of beats. A source presents its head beat and
//   pops it on a handshake. The reference model works at packet level. It
//   walks the source queues in rotating order, starting above the last
//   served source, and produces the exact sequence of output beats.
// ---------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int DATA_W = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            s_valid;
    logic [3:0]            s_last;
    logic [4*DATA_W-1:0]   s_data;
    logic [3:0]            s_ready;
    logic                  m_valid;
    logic                  m_last;
    logic [DATA_W-1:0]     m_data;
    logic [1:0]            m_src;
    logic                  m_ready;
    logic                  err;

    stream_rr_arbiter #(.DATA_W(DATA_W), .WDOG_CYC(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_data  (m_data),
        .m_src   (m_src),
        .m_ready (m_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              first;
    } beat_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [1:0]        src;
    } exp_t;

    beat_t srcq  [4][$];
    beat_t mdl_q [4][$];
    exp_t  exp_q [$];
    int    out_cyc [$];
    int    err_cyc [$];
    logic [1:0] obs_src [$];

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         acc_cnt = 0;
    logic [1:0] mdl_ptr = 2'd3;
    bit         ready_rand = 1'b0;
    bit         gap_en = 1'b0;
    int         hold_cnt = 0;
    logic [3:0] stall_src = 4'b0000;
    bit         hold_pending = 1'b0;
    bit         after_last = 1'b0;
    logic [DATA_W-1:0] h_data;
    logic              h_last;
    logic [1:0]        h_src;

    task automatic add_pkt(input int src, input int len, input logic [DATA_W-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = base + DATA_W'(k);
            b.last  = (k == len - 1);
            b.first = (k == 0);
            srcq[src].push_back(b);
        end
    endtask

    // Packet-level round robin over whatever is queued at the sources.
    task automatic build_expected();
        beat_t b;
        exp_t  e;
        logic [1:0] pick;
        logic [1:0] cand;
        bit found;
        for (int i = 0; i < 4; i++) mdl_q[i] = srcq[i];
        forever begin
            found = 1'b0;
            pick  = 2'd0;
            for (int k = 1; k <= 4; k++) begin
                cand = mdl_ptr + 2'(k);
                if (!found && mdl_q[cand].size() > 0) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
            if (!found) break;
            do begin
                b = mdl_q[pick].pop_front();
                e.data = b.data;
                e.last = b.last;
                e.src  = pick;
                exp_q.push_back(e);
            end while (!b.last);
            mdl_ptr = pick;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0) begin
                b = srcq[i][0];
                s_data[i*DATA_W +: DATA_W] = b.data;
                s_last[i]  = b.last;
                s_valid[i] = !(stall_src[i] && !b.first)
                             && !(gap_en && !b.first && ($urandom_range(0, 2) == 0));
            end else begin
                s_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                s_last[i]  = 1'($urandom);
                s_valid[i] = 1'b0;
            end
        end
        if (hold_cnt > 0) begin
            m_ready  = 1'b0;
            hold_cnt = hold_cnt - 1;
        end else begin
            m_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    // One clock: check at the falling edge, then update sources after the rising edge.
    task automatic step();
        exp_t e;
        logic [3:0] hs;
        @(negedge clk);
        cyc = cyc + 1;
        vectors++;
        if ($countones(s_ready) > 1) begin
            miscompares++;
            $display("FAIL ready_onehot cyc=%0d: s_ready=%b, required at most one bit", cyc, s_ready);
        end
        if (hold_pending) begin
            vectors++;
            if (m_valid !== 1'b1 || m_data !== h_data || m_last !== h_last || m_src !== h_src) begin
                miscompares++;
                $display("FAIL stall_stable cyc=%0d: got v=%b d=%h l=%b s=%0d, required v=1 d=%h l=%b s=%0d",
                         cyc, m_valid, m_data, m_last, m_src, h_data, h_last, h_src);
            end
        end
        if (m_valid === 1'b1 && m_ready === 1'b0) begin
            vectors++;
            if (s_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_ready cyc=%0d: s_ready=%b, required 0000", cyc, s_ready);
            end
        end
        if (after_last) begin
            vectors++;
            if (s_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle_gap cyc=%0d: s_ready=%b, required 0000", cyc, s_ready);
            end
        end
`ifndef ARB_WDOG_EN
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_tied cyc=%0d: err=%b, required 0", cyc, err);
        end
`endif
        if (err === 1'b1) err_cyc.push_back(cyc);
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_beat cyc=%0d: got d=%h s=%0d, required no beat", cyc, m_data, m_src);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_last !== e.last || m_src !== e.src) begin
                    miscompares++;
                    $display("FAIL beat cyc=%0d: got d=%h l=%b s=%0d, required d=%h l=%b s=%0d",
                             cyc, m_data, m_last, m_src, e.data, e.last, e.src);
                end
                out_cyc.push_back(cyc);
                obs_src.push_back(m_src);
            end
        end
        hs = s_valid & s_ready;
        hold_pending = (m_valid === 1'b1) && (m_ready === 1'b0);
        h_data = m_data;
        h_last = m_last;
        h_src  = m_src;
        after_last = |(hs & s_last);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                acc_cnt++;
            end
        end
        drive();
    endtask

    task automatic run(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        exp_q.delete();
        hold_pending = 1'b0;
        after_last   = 1'b0;
        mdl_ptr      = 2'd3;
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 4'hF;
        s_last = 4'h0;
        s_data = 32'($urandom);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors += 6;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        if (m_last !== 1'b0) begin miscompares++; $display("FAIL rst_m_last: got %b, required 0", m_last); end
        if (m_data !== '0) begin miscompares++; $display("FAIL rst_m_data: got %h, required 00", m_data); end
        if (m_src !== 2'd0) begin miscompares++; $display("FAIL rst_m_src: got %0d, required 0", m_src); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", err); end
        if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_s_ready: got %b, required 0000", s_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        vectors++;
        if (s_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_rst_s_ready: got %b, required 0000", s_ready);
        end
        @(posedge clk);
        #1;
        mdl_ptr = 2'd3;
    endtask

    task automatic test_single_packet();
        int start;
        add_pkt(0, 4, 8'h10);
        build_expected();
        drive();
        start = cyc;
        out_cyc.delete();
        run("single", 50);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_cyc.size() <= k || out_cyc[k] != start + 3 + k) begin
                miscompares++;
                $display("FAIL latency beat%0d: got cycle %0d, required %0d", k,
                         (out_cyc.size() > k) ? out_cyc[k] - start : -1, 3 + k);
            end
        end
    endtask

    task automatic test_two_sources();
        do_reset();
        add_pkt(0, 4, 8'($urandom));
        add_pkt(1, 6, 8'($urandom));
        build_expected();
        drive();
        run("two_src", 80);
    endtask

    task automatic test_rotation();
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 4; s++)
                add_pkt(s, 2, 8'($urandom));
        build_expected();
        drive();
        obs_src.delete();
        run("rotation", 200);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs_src.size() <= 2*k || obs_src[2*k] !== 2'(k % 4)) begin
                miscompares++;
                $display("FAIL rotation_pkt%0d: got src %0d, required %0d", k,
                         (obs_src.size() > 2*k) ? int'(obs_src[2*k]) : -1, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        add_pkt(2, 6, 8'($urandom));
        build_expected();
        drive();
        out_cyc.delete();
        while (out_cyc.size() < 2 && n < 20) begin
            step();
            n++;
        end
        hold_cnt = 3;
        run("backpressure", 60);
    endtask

    task automatic test_reset_abort();
        int n = 0;
        add_pkt(1, 6, 8'($urandom));
        build_expected();
        drive();
        acc_cnt = 0;
        while (acc_cnt < 2 && n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        exp_q.delete();
        hold_pending = 1'b0;
        after_last   = 1'b0;
        mdl_ptr      = 2'd3;
        drive();
        @(negedge clk);
        vectors += 2;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL abort_m_valid: got %b, required 0", m_valid); end
        if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL abort_s_ready: got %b, required 0000", s_ready); end
        @(posedge clk);
        #1;
        add_pkt(3, 3, 8'($urandom));
        add_pkt(1, 4, 8'($urandom));
        add_pkt(2, 2, 8'($urandom));
        build_expected();
        drive();
        obs_src.delete();
        run("reset_abort", 80);
        vectors++;
        if (obs_src.size() == 0 || obs_src[0] !== 2'd1) begin
            miscompares++;
            $display("FAIL abort_regrant: got src %0d, required 1",
                     (obs_src.size() > 0) ? int'(obs_src[0]) : -1);
        end
    endtask

    task automatic test_random();
        ready_rand = 1'b1;
        gap_en = 1'b1;
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < 4; s++)
                for (int p = 0; p < int'($urandom_range(0, 2)); p++)
                    add_pkt(s, $urandom_range(1, 5), 8'($urandom));
            build_expected();
            drive();
            run("random", 800);
        end
        ready_rand = 1'b0;
        gap_en = 1'b0;
        drive();
    endtask

`ifdef ARB_WDOG_EN
    task automatic test_watchdog();
        beat_t b;
        exp_t e;
        do_reset();
        stall_src = 4'b0001;
        add_pkt(0, 3, 8'($urandom));
        add_pkt(1, 3, 8'($urandom));
        b = srcq[0][0];
        e.data = b.data; e.last = b.last; e.src = 2'd0;
        exp_q.push_back(e);
        for (int k = 0; k < 3; k++) begin
            b = srcq[1][k];
            e.data = b.data; e.last = b.last; e.src = 2'd1;
            exp_q.push_back(e);
        end
        drive();
        out_cyc.delete();
        err_cyc.delete();
        run("watchdog", 80);
        vectors++;
        if (err_cyc.size() != 1 || out_cyc.size() == 0 || err_cyc[0] != out_cyc[0] + 16) begin
            miscompares++;
            $display("FAIL wdog_err: got %0d pulses, first at +%0d, required 1 pulse at +16", err_cyc.size(),
                     (err_cyc.size() > 0 && out_cyc.size() > 0) ? err_cyc[0] - out_cyc[0] : -1);
        end
        srcq[0].delete();
        stall_src = 4'b0000;
        mdl_ptr = 2'd0;
        drive();
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_two_sources();
        test_rotation();
        test_backpressure();
        test_reset_abort();
        test_random();
`ifdef ARB_WDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of every data bus.
REQ-002 Parameter WDOG_CYC, default 16, stall-cycle limit for the watchdog (Configuration).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  4  per-source beat valid.
REQ-006 s_last  input  4  per-source last beat of packet.
REQ-007 s_data  input  4*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 s_ready  output  4  per-source ready; at most one bit high per cycle.
REQ-009 m_valid  output  1  output beat valid (registered).
REQ-010 m_last  output  1  output last beat (registered).
REQ-011 m_data  output  DATA_W  output data (registered).
REQ-012 m_src  output  2  index of the source that produced the current output beat (registered).
REQ-013 m_ready  input  1  downstream ready.
REQ-014 err  output  1  one-cycle watchdog abort pulse; constant 0 when the watchdog is compiled out.

Function
REQ-015 FSM states: IDLE (no grant) and BUSY (grant held by source g).
REQ-016 IDLE: if any s_valid is set, select the first set bit searching upward from (ptr+1) mod 4, load g, and enter BUSY next cycle; s_ready = 0 in IDLE.
REQ-017 BUSY: s_ready[g] = !m_valid || m_ready; all other s_ready bits = 0.
REQ-018 Input beat accepted when s_valid[g] && s_ready[g]; on the same edge load m_data, m_last, m_src=g and set m_valid=1.
REQ-019 Output register cleared (m_valid=0) on an edge with m_valid && m_ready and no new accepted beat.
REQ-020 Latency: an accepted input beat appears on the m_* outputs the next cycle; throughput 1 beat/cycle within a packet while m_ready=1.
REQ-021 Grant held until the beat with s_last[g]=1 is accepted; on that edge set ptr=g and return to IDLE.
REQ-022 Minimum one IDLE cycle between packets; the next grant decision uses the updated ptr.
REQ-023 Non-granted sources are never dropped; their s_valid/s_data are held by the source and ignored by the arbiter.
REQ-024 Single requester in IDLE: granted regardless of ptr.
REQ-025 m_valid && !m_ready: the m_* outputs stay stable and s_ready[g]=0 (no overwrite).
REQ-026 Fairness: with all four sources continuously requesting, grant order is strictly rotating; no source waits for more than 3 packets.

Reset
REQ-027 When rst=1 at a rising edge: state=IDLE, ptr=3 (first grant search starts at source 0), g=0, m_valid=0, m_last=0, m_data=0, m_src=0, err=0, watchdog counter=0.
REQ-028 Reset asserted mid-packet aborts the packet immediately; no partial beat is presented after reset.
REQ-029 s_ready is 0 throughout reset and for the cycle following reset.

Configuration
REQ-030 Macro ARB_WDOG_EN.
REQ-031 Defined: in BUSY, a counter increments on each cycle with s_valid[g]=0 and clears on each accepted beat.
REQ-032 Defined: when the counter reaches WDOG_CYC, the next edge returns to IDLE with ptr=g, pulses err for one cycle, and emits no synthetic last beat.
REQ-033 Not defined: no counter logic is present, err is tied to 0, and a stalled grant is held indefinitely.

Verification
REQ-034 After reset, src0 sends a 4-beat packet (0x10..0x13) with m_ready=1 -> m_data shows 0x10..0x13 on 4 consecutive cycles starting 2 cycles after s_valid[0] rises; m_last on 0x13; m_src=0.
REQ-035 src0 and src1 request together with ptr=3 -> src0 is granted and its 4 beats complete, then src1 sends 6 beats with m_src=1; no beats interleave.
REQ-036 All 4 sources request continuously with 2-beat packets -> m_src order is 0,1,2,3,0,...
REQ-037 m_ready held 0 for 3 cycles mid-packet -> m_data is stable during the hold, s_ready[g]=0, and no beat is lost or duplicated.
REQ-038 rst pulsed during beat 2 of a 6-beat packet -> next cycle m_valid=0 and state is IDLE; the next grant goes to the lowest-index requester.
REQ-039 With ARB_WDOG_EN and WDOG_CYC=16, the granted source drops s_valid after beat 1 -> err pulses exactly 16 cycles later and another requester is granted.
